// File: rtl/spi_rom_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_rom_fetch_if
// Purpose  : Request/response bundle between the 6-bit scrap CPU core and the
//            SPI ROM byte-fetch engine.
// Signals  : req          - fetch request, held by the core until accepted
//            req_addr     - 12-bit byte address, captured with req
//            double_speed - 0: SCLK = clk/4, 1: SCLK = clk/2 (sampled at accept)
//            ready        - engine can accept a request
//            rvalid       - one-cycle pulse, rdata valid
//            rdata        - fetched byte, held until the next rvalid
// Modports : master (core side), slave (fetch engine side)
// Revision : 1.0 - initial release
// ============================================================================
interface spi_rom_fetch_if;
  logic        req;
  logic [11:0] req_addr;
  logic        double_speed;
  logic        ready;
  logic        rvalid;
  logic [7:0]  rdata;

  modport master (
    output req, req_addr, double_speed,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, req_addr, double_speed,
    output ready, rvalid, rdata
  );
endinterface
`default_nettype wire

// File: rtl/spi_rom_fetch.sv
`default_nettype none
// ============================================================================
// Module   : spi_rom_fetch
// Purpose  : Byte-fetch engine for a 25-series SPI NOR flash (READ, 0x03).
//            A request that continues the previous address keeps the flash
//            selected and clocks out only the next byte; any other request
//            deselects the flash and issues command + 24-bit address + one
//            byte clocked in as data.
// Ports    : clk   - core clock
//            rst_n - asynchronous active-low reset
//            bus   - spi_rom_fetch_if.slave (req/req_addr/double_speed in,
//                    ready/rvalid/rdata out)
//            cs_n, sclk, mosi - flash outputs (SPI mode 0), all registered
//            miso  - flash data out
// Config   : SPI_ROM_PREFETCH_EN - when defined, a one-entry prefetch buffer
//            fetches last_addr+1 while the core is idle.
// Revision : 1.0 - initial release
// ============================================================================
module spi_rom_fetch (
  input  wire logic          clk,
  input  wire logic          rst_n,
  spi_rom_fetch_if.slave     bus,
  output logic               cs_n,
  output logic               sclk,
  output logic               mosi,
  input  wire logic          miso
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DESEL = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CMD_READ = 8'h03;

  state_t      state;
  logic [11:0] addr_q;      // address of the byte being fetched
  logic [11:0] last_addr;   // address of the last byte handed to the core
  logic        sess_open;   // flash selected and positioned at last_addr+1
  logic        d_one;       // latched half-period: 1 -> d=1, 0 -> d=2
  logic        half_cnt;    // clk edges remaining in the current half-period
  logic        desel_cnt;
  logic [5:0]  bits_left;
  logic [39:0] tx_sh;       // bits still to go out; MSB is the next mosi bit
  logic [7:0]  rx_sh;
  logic        ready_q;
  logic        rvalid_q;
  logic [7:0]  rdata_q;

`ifdef SPI_ROM_PREFETCH_EN
  logic        pf_run;      // current SHIFT fills the prefetch buffer
  logic        pvalid;
  logic [7:0]  pbuf;
  logic [11:0] paddr;
`endif

  // Sequential test is done at 13 bits so 0xFFF -> 0x000 is not a hit: the
  // flash would continue at 0x1000, not wrap to 0.
  logic [12:0] next_seq;
  logic        seq_hit;
  logic        accept;

  assign next_seq = {1'b0, last_addr} + 13'd1;
  assign seq_hit  = sess_open && (next_seq == {1'b0, bus.req_addr});
  assign accept   = bus.req && ready_q;

`ifdef SPI_ROM_PREFETCH_EN
  logic pbuf_hit;
  logic pf_start;
  assign pbuf_hit = pvalid && (bus.req_addr == paddr);
  assign pf_start = !bus.req && sess_open && !pvalid && (last_addr != 12'hFFF);
`endif

  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_q    <= 12'h000;
      last_addr <= 12'h000;
      sess_open <= 1'b0;
      d_one     <= 1'b0;
      half_cnt  <= 1'b0;
      desel_cnt <= 1'b0;
      bits_left <= 6'd0;
      tx_sh     <= 40'h0;
      rx_sh     <= 8'h00;
      ready_q   <= 1'b1;
      rvalid_q  <= 1'b0;
      rdata_q   <= 8'h00;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
`ifdef SPI_ROM_PREFETCH_EN
      pf_run    <= 1'b0;
      pvalid    <= 1'b0;
      pbuf      <= 8'h00;
      paddr     <= 12'h000;
`endif
    end else begin
      rvalid_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr;
            d_one   <= bus.double_speed;
            ready_q <= 1'b0;
`ifdef SPI_ROM_PREFETCH_EN
            if (pbuf_hit) begin
              // Byte already buffered: hand it over through DONE next edge.
              rx_sh  <= pbuf;
              pvalid <= 1'b0;
              state  <= S_DONE;
            end else
`endif
            if (seq_hit) begin
              // Flash already sits on this byte; clock out one dummy byte.
              // The first (zero) bit is presented now, sclk still low.
              state     <= S_SHIFT;
              tx_sh     <= 40'h0;
              bits_left <= 6'd8;
              half_cnt  <= !bus.double_speed;
              mosi      <= 1'b0;
            end else begin
              state     <= S_DESEL;
              cs_n      <= 1'b1;
              sclk      <= 1'b0;
              mosi      <= 1'b0;
              sess_open <= 1'b0;
              desel_cnt <= 1'b0;
              tx_sh     <= {CMD_READ, 8'h00, 4'h0, bus.req_addr[11:8],
                            bus.req_addr[7:0], 8'h00};
              bits_left <= 6'd40;
`ifdef SPI_ROM_PREFETCH_EN
              pvalid    <= 1'b0;
`endif
            end
          end
`ifdef SPI_ROM_PREFETCH_EN
          else if (pf_start) begin
            // Idle core: pull the next sequential byte with the last speed.
            ready_q   <= 1'b0;
            pf_run    <= 1'b1;
            addr_q    <= next_seq[11:0];
            state     <= S_SHIFT;
            tx_sh     <= 40'h0;
            bits_left <= 6'd8;
            half_cnt  <= !d_one;
            mosi      <= 1'b0;
          end
`endif
        end

        S_DESEL: begin
          // cs_n stays high for exactly two clk, then the first command bit
          // is presented together with the falling cs_n.
          if (desel_cnt) begin
            state    <= S_SHIFT;
            cs_n     <= 1'b0;
            mosi     <= tx_sh[39];
            tx_sh    <= {tx_sh[38:0], 1'b0};
            half_cnt <= !d_one;
          end else begin
            desel_cnt <= 1'b1;
          end
        end

        S_SHIFT: begin
          if (half_cnt) begin
            half_cnt <= 1'b0;
          end else begin
            half_cnt <= !d_one;
            if (!sclk) begin
              // Rising sclk: the flash has had the whole low half to drive miso.
              sclk  <= 1'b1;
              rx_sh <= {rx_sh[6:0], miso};
            end else begin
              // Falling sclk: mosi advances only here, while sclk goes low.
              sclk <= 1'b0;
              if (bits_left == 6'd1) begin
                state <= S_DONE;
              end else begin
                bits_left <= bits_left - 6'd1;
                mosi      <= tx_sh[39];
                tx_sh     <= {tx_sh[38:0], 1'b0};
              end
            end
          end
        end

        S_DONE: begin
`ifdef SPI_ROM_PREFETCH_EN
          if (pf_run) begin
            pbuf   <= rx_sh;
            paddr  <= addr_q;
            pvalid <= 1'b1;
            pf_run <= 1'b0;
          end else
`endif
          begin
            rdata_q   <= rx_sh;
            rvalid_q  <= 1'b1;
            last_addr <= addr_q;
          end
          sess_open <= 1'b1;
          ready_q   <= 1'b1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_rom_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_rom_fetch
// Purpose  : Directed self-checking bench for spi_rom_fetch with a behavioural
//            SPI NOR flash model (READ command, mode 0, streaming output).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_rom_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs_n, sclk, mosi;
  logic miso = 1'b0;

  spi_rom_fetch_if bus ();

  spi_rom_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .cs_n  (cs_n),
    .sclk  (sclk),
    .mosi  (mosi),
    .miso  (miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Flash content: 0x123 holds 0xA5, everything else a fixed pattern.
  function automatic logic [7:0] fmem(input logic [11:0] a);
    if (a == 12'h123) return 8'hA5;
    return a[7:0] ^ {a[11:8], 4'h0} ^ 8'h3C;
  endfunction

  // ---------------- flash model ----------------
  int          fbit = 0;
  logic [31:0] fcmd = 32'h0;
  logic [11:0] fa;
  logic [7:0]  fb;
  int          fk;

  always @(negedge cs_n) fbit = 0;

  always @(posedge sclk) begin
    if (!cs_n) begin
      if (fbit < 32) fcmd = {fcmd[30:0], mosi};
      fbit++;
    end
  end

  always @(negedge sclk) begin
    if (!cs_n && fbit >= 32) begin
      fk = (fbit - 32) % 8;
      fa = fcmd[11:0] + 12'((fbit - 32) / 8);
      fb = fmem(fa);
      miso <= fb[7 - fk];
    end
  end

  // ---------------- observation ----------------
  int          rises = 0;
  logic [63:0] mosi_log = 64'h0;
  int          cs_toggles = 0;
  int          wide_err = 0;
  logic        rv_prev = 1'b0;

  always @(posedge sclk) begin
    rises++;
    mosi_log = {mosi_log[62:0], mosi};
  end

  always @(cs_n) cs_toggles++;

  always @(negedge clk) begin
    if (rv_prev && bus.rvalid) wide_err++;
    rv_prev = bus.rvalid;
  end

  // Issue one request; lat = edges from accept to rvalid, cshi = cycles with
  // cs_n high after accept.
  task automatic run_req(input logic [11:0] a, input logic ds, input logic flip,
                         output int lat, output int cshi);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.ready) check_val("ready_timeout", 0, 1);
    bus.req = 1'b1;
    bus.req_addr = a;
    bus.double_speed = ds;
    @(posedge clk);
    rises = 0;
    mosi_log = 64'h0;
    cs_toggles = 0;
    #1;
    bus.req = 1'b0;
    if (flip) bus.double_speed = ~ds;
    lat = 0;
    cshi = 0;
    while (!bus.rvalid && lat < 400) begin
      cshi += int'(cs_n);
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.rvalid) check_val("rvalid_timeout", 0, 1);
    else check_val("ready_with_rvalid", 64'(bus.ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int lat, cshi, g;

  initial begin
    bus.req = 1'b0;
    bus.req_addr = 12'h000;
    bus.double_speed = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready",  64'(bus.ready), 1);
    check_val("rst_rvalid", 64'(bus.rvalid), 0);
    check_val("rst_rdata",  64'(bus.rdata), 0);
    check_val("rst_cs_n",   64'(cs_n), 1);
    check_val("rst_sclk",   64'(sclk), 0);
    check_val("rst_mosi",   64'(mosi), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Miss at d=2
    run_req(12'h123, 1'b0, 1'b0, lat, cshi);
    check_val("t1_lat",   lat, 163);
    check_val("t1_cshi",  cshi, 2);
    check_val("t1_rdata", 64'(bus.rdata), 64'hA5);
    check_val("t1_rises", rises, 40);
    check_val("t1_mosi",  mosi_log[39:0], 40'h0300012300);

    // Back-to-back sequential hit
    run_req(12'h124, 1'b0, 1'b0, lat, cshi);
    check_val("t2_lat",    lat, 33);
    check_val("t2_cshi",   cshi, 0);
    check_val("t2_cs_tog", cs_toggles, 0);
    check_val("t2_rises",  rises, 8);
    check_val("t2_rdata",  64'(bus.rdata), 64'h08);

    // 0xFFF then 0x000 must not be treated as sequential
    run_req(12'hFFF, 1'b0, 1'b0, lat, cshi);
    check_val("t3a_lat",   lat, 163);
    check_val("t3a_rdata", 64'(bus.rdata), 64'h33);
    run_req(12'h000, 1'b0, 1'b0, lat, cshi);
    check_val("t3b_lat",   lat, 163);
    check_val("t3b_cshi",  cshi, 2);
    check_val("t3b_mosi",  mosi_log[39:8], 32'h03000000);
    check_val("t3b_rdata", 64'(bus.rdata), 64'h3C);

    // d=1 miss, then hit with double_speed flipped mid-transfer
    run_req(12'h010, 1'b1, 1'b0, lat, cshi);
    check_val("t4a_lat",   lat, 83);
    check_val("t4a_rdata", 64'(bus.rdata), 64'h2C);
    run_req(12'h011, 1'b1, 1'b1, lat, cshi);
    check_val("t4b_lat",   lat, 17);
    check_val("t4b_rises", rises, 8);
    check_val("t4b_rdata", 64'(bus.rdata), 64'h2D);

    // Asynchronous reset during byte 3 of a miss
    @(negedge clk);
    bus.req = 1'b1;
    bus.req_addr = 12'h123;
    bus.double_speed = 1'b0;
    @(posedge clk);
    rises = 0;
    #1;
    bus.req = 1'b0;
    g = 0;
    while (rises < 20 && g < 400) begin
      @(posedge clk);
      g++;
    end
    check_val("t5_reach_byte3", 64'(rises >= 20), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_val("t5_cs_n",   64'(cs_n), 1);
    check_val("t5_sclk",   64'(sclk), 0);
    check_val("t5_ready",  64'(bus.ready), 1);
    check_val("t5_rvalid", 64'(bus.rvalid), 0);
    check_val("t5_mosi",   64'(mosi), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(12'h124, 1'b0, 1'b0, lat, cshi);
    check_val("t5_lat",   lat, 163);
    check_val("t5_cshi",  cshi, 2);
    check_val("t5_mosi_cmd", mosi_log[39:8], 32'h03000124);
    check_val("t5_rdata", 64'(bus.rdata), 64'h08);

`ifdef SPI_ROM_PREFETCH_EN
    run_req(12'h200, 1'b0, 1'b0, lat, cshi);
    check_val("pf_a_lat",   lat, 163);
    check_val("pf_a_rdata", 64'(bus.rdata), 64'h1C);
    g = 0;
    while (bus.ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    while (!bus.ready && g < 400) begin
      @(negedge clk);
      g++;
    end
    check_val("pf_done", 64'(bus.ready), 1);
    run_req(12'h201, 1'b0, 1'b0, lat, cshi);
    check_val("pf_b_lat",   lat, 1);
    check_val("pf_b_rdata", 64'(bus.rdata), 64'h1D);
    run_req(12'h300, 1'b0, 1'b0, lat, cshi);
    check_val("pf_c_lat",   lat, 163);
    check_val("pf_c_rdata", 64'(bus.rdata), 64'h0C);
`endif

    repeat (2) @(posedge clk);
    check_val("rvalid_width", wide_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
